// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: issue, writeback and read-port bundle for the register file
interface regfile_mp_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);
  logic              init_busy;
  logic              we0;
  logic [AW-1:0]     wa0;
  logic [XLEN-1:0]   wd0;
  logic              we1;
  logic [AW-1:0]     wa1;
  logic [XLEN-1:0]   wd1;
  logic              iss_valid;
  logic [AW-1:0]     iss_addr;
  logic [NRD*AW-1:0] rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]    rs_pend;
  modport master (
    input  init_busy, rs_data, rs_pend,
    output we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_addr, rs_addr
  );
  modport slave (
    output init_busy, rs_data, rs_pend,
    input  we0, wa0, wd0, we1, wa1, wd1, iss_valid, iss_addr, rs_addr
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read, dual-write register file with scoreboard and post-reset clear sequencer
module regfile_mp_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic sysclk,
  input logic sysreset_n,
  regfile_mp_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  logic [0:0]          state;
  logic [AW-1:0]       cnt;
  logic [NREGS-1:0]    pend, pend_nxt;
  logic [XLEN-1:0]     mem [NREGS];
  logic                run, w0, w1, iss;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rp;
  assign run = state == S_RUN;
  assign w0  = run && bus.we0 && !(ZERO_REG != 0 && bus.wa0 == '0);
  assign w1  = run && bus.we1 && !(ZERO_REG != 0 && bus.wa1 == '0);
  assign iss = run && bus.iss_valid && !(ZERO_REG != 0 && bus.iss_addr == '0);
  assign bus.init_busy = !run;
  assign bus.rs_data = rd;
  assign bus.rs_pend = rp;
  // Clear sequencer: walk cnt across the array once after reset, then park in RUN
  always_ff @(posedge sysclk or negedge sysreset_n)
    if (!sysreset_n) begin
      state <= S_INIT;
      cnt   <= '0;
    end else if (!run) begin
      cnt   <= cnt + 1'b1;
      state <= (cnt == AW'(NREGS - 1)) ? S_RUN : S_INIT;
    end
  // Scoreboard update: writebacks retire a producer, a same-cycle issue installs a newer one
  always_comb begin
    pend_nxt = pend;
    if (w0) pend_nxt[bus.wa0] = 1'b0;
    if (w1) pend_nxt[bus.wa1] = 1'b0;
    if (iss) pend_nxt[bus.iss_addr] = 1'b1;
  end
  // Scoreboard state, cleared asynchronously so no stale producer survives reset
  always_ff @(posedge sysclk or negedge sysreset_n)
    if (!sysreset_n) pend <= '0;
    else pend <= pend_nxt;
  // Array has no reset so it maps to distributed RAM; the load port is written last and wins
  always_ff @(posedge sysclk)
    if (!run) mem[cnt] <= '0;
    else begin
      if (w0) mem[bus.wa0] <= bus.wd0;
      if (w1) mem[bus.wa1] <= bus.wd1;
    end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          h0, h1;
    assign ra = bus.rs_addr[k*AW +: AW];
    assign h0 = BYPASS != 0 && w0 && bus.wa0 == ra;
    assign h1 = BYPASS != 0 && w1 && bus.wa1 == ra;
    assign rd[k*XLEN +: XLEN] = !run ? '0 : h1 ? bus.wd1 : h0 ? bus.wd0 :
                                (ZERO_REG != 0 && ra == '0) ? '0 : mem[ra];
    assign rp[k] = run && pend[ra] && !h0 && !h1;
  end
endmodule
